// File: rtl/temp_sense_pkg.sv
// Shared types and default constants for the temperature-sensor ring-oscillator readout.
package temp_sense_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int CNT_W_DEF      = 24;
  localparam int WIN_W_DEF      = 5;
  localparam int WIN_MAX_DEF    = 20;
  localparam int SETTLE_CYC_DEF = 16;

  // Consecutive equal-sample cycles that flag a broken differential pair.
  localparam int FAULT_RUN      = 3;

endpackage

// File: rtl/temp_sense_sync.sv
// Oscillator input conditioning: 2-FF synchronizers, OSC_P rising-edge detect and
// run-length detector for non-complementary OSC_P/OSC_N samples.
module temp_sense_sync
  import temp_sense_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic osc_p,
  input  logic osc_n,
  input  logic qual,
  output logic rise,
  output logic run_hit
);

  localparam int RUN_W = $clog2(FAULT_RUN + 1);

  logic [2:0]       p_sync_r;
  logic [1:0]       n_sync_r;
  logic [RUN_W-1:0] run_r;
  logic             eq_s;

  // Synchronizer chains; the third OSC_P stage only feeds the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_sync_r <= 3'b000;
      n_sync_r <= 2'b00;
    end else begin
      p_sync_r <= {p_sync_r[1:0], osc_p};
      n_sync_r <= {n_sync_r[0], osc_n};
    end
  end

  assign eq_s    = (p_sync_r[1] == n_sync_r[1]);
  assign rise    = p_sync_r[1] & ~p_sync_r[2];
  assign run_hit = (run_r == RUN_W'(FAULT_RUN));

  // Saturating run of equal samples, restarted outside the qualifying window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r <= '0;
    end else if (qual && eq_s) begin
      if (run_r != RUN_W'(FAULT_RUN)) begin
        run_r <= run_r + RUN_W'(1);
      end else begin
        run_r <= run_r;
      end
    end else begin
      run_r <= '0;
    end
  end

endmodule

// File: rtl/temp_sense_counter.sv
// Ring-oscillator temperature readout: settles the oscillator, counts its edges over a
// 2^win reference-cycle window and holds the result with DONE/OVF/FAULT status.
module temp_sense_counter
  import temp_sense_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int WIN_MAX    = WIN_MAX_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             CLK_REF,
  input  logic             RESETn,
  input  logic             START,
  input  logic [WIN_W-1:0] SEL_WIN,
  output logic             EN,
  input  logic             OSC_P,
  input  logic             OSC_N,
  output logic [CNT_W-1:0] DOUT,
  output logic             DONE,
  output logic             BUSY,
  output logic             OVF,
  output logic             FAULT
);

  localparam int WC_W = WIN_MAX + 1;
  localparam int ST_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_r, state_s;
  logic [WIN_W-1:0] win_r, sel_clamp_s;
  logic [WC_W-1:0]  win_cnt_r, win_term_s;
  logic [ST_W-1:0]  settle_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             start_ok_s, settle_end_s, win_end_s, in_count_s, load_s;
  logic             rise_s, run_hit_s, ovf_hit_s, fault_hit_s;

  temp_sense_sync u_sync (
    .clk     (CLK_REF),
    .rst_n   (RESETn),
    .osc_p   (OSC_P),
    .osc_n   (OSC_N),
    .qual    (in_count_s),
    .rise    (rise_s),
    .run_hit (run_hit_s)
  );

  // Decode of control conditions and the saturating edge-count increment.
  always_comb begin
    start_ok_s   = START && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    sel_clamp_s  = (SEL_WIN > WIN_W'(WIN_MAX)) ? WIN_W'(WIN_MAX) : SEL_WIN;
    win_term_s   = (WC_W'(1) << win_r) - WC_W'(1);
    settle_end_s = (settle_r == ST_W'(SETTLE_CYC));
    win_end_s    = (win_cnt_r == win_term_s);
    in_count_s   = (state_r == ST_COUNT);
    load_s       = in_count_s && win_end_s;
    cnt_s        = cnt_r;
    if (in_count_s && rise_s && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
    ovf_hit_s   = in_count_s && (cnt_s == CNT_MAX);
    fault_hit_s = in_count_s && run_hit_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) state_s = ST_SETTLE;
        else            state_s = state_r;
      end
      ST_SETTLE: begin
        if (settle_end_s) state_s = ST_COUNT;
        else              state_s = ST_SETTLE;
      end
      ST_COUNT: begin
        if (win_end_s) state_s = ST_DONE;
        else           state_s = ST_COUNT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_REF or negedge RESETn) begin
    if (!RESETn) state_r <= ST_IDLE;
    else         state_r <= state_s;
  end

  // Settle timer, window timer, latched window and edge counter.
  always_ff @(posedge CLK_REF or negedge RESETn) begin
    if (!RESETn) begin
      settle_r  <= '0;
      win_cnt_r <= '0;
      win_r     <= '0;
      cnt_r     <= '0;
    end else if (start_ok_s) begin
      settle_r  <= '0;
      win_cnt_r <= '0;
      win_r     <= sel_clamp_s;
      cnt_r     <= '0;
    end else begin
      if ((state_r == ST_SETTLE) && !settle_end_s) settle_r <= settle_r + ST_W'(1);
      else                                         settle_r <= settle_r;
      if (in_count_s && !win_end_s) win_cnt_r <= win_cnt_r + WC_W'(1);
      else                          win_cnt_r <= win_cnt_r;
      win_r <= win_r;
      cnt_r <= cnt_s;
    end
  end

  // Registered outputs; status flags are sticky until the next accepted START.
  always_ff @(posedge CLK_REF or negedge RESETn) begin
    if (!RESETn) begin
      EN    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      DOUT  <= '0;
      OVF   <= 1'b0;
      FAULT <= 1'b0;
    end else begin
      EN   <= (state_s == ST_SETTLE) || (state_s == ST_COUNT);
      BUSY <= (state_s == ST_SETTLE) || (state_s == ST_COUNT);
      DONE <= (state_s == ST_DONE);
      if (load_s) DOUT <= cnt_s;
      else        DOUT <= DOUT;
      if (start_ok_s)     OVF <= 1'b0;
      else if (ovf_hit_s) OVF <= 1'b1;
      else                OVF <= OVF;
      if (start_ok_s)       FAULT <= 1'b0;
      else if (fault_hit_s) FAULT <= 1'b1;
      else                  FAULT <= FAULT;
    end
  end

endmodule
